core_run_ctrl: RTL and testbench

Run-control sequencer for the single-cycle RV32I core. Generates the core's execute enable, so the core can be halted, free-run or single-stepped. Halts on a PC breakpoint or an invalid instruction and counts retired instructions. Sits between the top-level wrapper (switches/debug inputs) and the datapath: `o_core_en` gates every architectural state update (PC, register file write, data-memory/IO write), and `i_pc`/`i_insn_vld` come back from the core.

---
 rtl/run_ctrl_pkg.sv | 18 +
 rtl/core_run_ctrl.sv | 92 +++++++++
 tb/tb_core_run_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: state and halt-cause encodings shared by the run-control sequencer.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        CAUSE_NONE      = 3'd0,
        CAUSE_HALT_REQ  = 3'd1,
        CAUSE_STEP_DONE = 3'd2,
        CAUSE_BP        = 3'd3,
        CAUSE_ILLEGAL   = 3'd4
    } cause_t;

endpackage

// File: rtl/core_run_ctrl.sv
// core_run_ctrl: halt/run/single-step sequencer producing the core execute enable.
module core_run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter bit RESET_RUN = 1'b0,
    parameter int STEP_W    = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_run_req,
    input  logic              i_halt_req,
    input  logic              i_step_req,
    input  logic [STEP_W-1:0] i_step_num,
    input  logic              i_bp_en,
    input  logic [31:0]       i_bp_addr,
    input  logic [31:0]       i_pc,
    input  logic              i_insn_vld,
    output logic              o_core_en,
    output logic              o_halted,
    output logic [2:0]        o_halt_cause,
    output logic [31:0]       o_retired,
    output logic [STEP_W-1:0] o_step_left
);

    localparam state_t RESET_STATE = RESET_RUN ? ST_RUN : ST_HALT;

    state_t            state, state_nx;
    cause_t            cause, cause_nx;
    logic [31:0]       retired;
    logic [STEP_W-1:0] step_left, step_nx;
    logic              bp_skip, skip_nx;
    logic              bp_hit, core_en;

    assign bp_hit  = i_bp_en && (i_pc == i_bp_addr) && !bp_skip;
    // Gated by reset so execution stops the instant reset asserts, even with RESET_RUN.
    assign core_en = i_reset && (state != ST_HALT) && i_insn_vld && !bp_hit;

    always_comb begin
        state_nx = state;
        cause_nx = cause;
        step_nx  = step_left;
        skip_nx  = bp_skip && !core_en;
        if (state == ST_HALT) begin
            if (i_step_req) begin
                state_nx = ST_STEP;
                step_nx  = (i_step_num == '0) ? STEP_W'(1) : i_step_num;
            end else if (i_run_req) begin
                state_nx = ST_RUN;
            end
            if (i_step_req || i_run_req) begin
                skip_nx  = 1'b1;
                cause_nx = CAUSE_NONE;
            end
        end else if (i_halt_req) begin
            state_nx = ST_HALT;
            cause_nx = CAUSE_HALT_REQ;
        end else if (!i_insn_vld) begin
            state_nx = ST_HALT;
            cause_nx = CAUSE_ILLEGAL;
        end else if (bp_hit) begin
            state_nx = ST_HALT;
            cause_nx = CAUSE_BP;
        end else if (state == ST_STEP) begin
            state_nx = (step_left == STEP_W'(1)) ? ST_HALT : ST_STEP;
            cause_nx = (step_left == STEP_W'(1)) ? CAUSE_STEP_DONE : cause;
            step_nx  = step_left - STEP_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state     <= RESET_STATE;
            cause     <= CAUSE_NONE;
            retired   <= '0;
            step_left <= '0;
            bp_skip   <= 1'b1;
        end else begin
            state     <= state_nx;
            cause     <= cause_nx;
            retired   <= core_en ? retired + 32'd1 : retired;
            step_left <= step_nx;
            bp_skip   <= skip_nx;
        end
    end

    assign o_core_en    = core_en;
    assign o_halted     = (state == ST_HALT);
    assign o_halt_cause = cause;
    assign o_retired    = retired;
    assign o_step_left  = step_left;

endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl: scoreboard bench comparing core_run_ctrl against a cycle-level reference model.
module tb_core_run_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run_req, halt_req, step_req, bp_en, insn_vld;
    logic [15:0] step_num;
    logic [31:0] bp_addr, pc;
    logic        core_en, halted;
    logic [2:0]  cause;
    logic [31:0] retired;
    logic [15:0] step_left;

    always #5 clk = ~clk;

    core_run_ctrl dut (
        .i_clk(clk), .i_reset(reset), .i_run_req(run_req), .i_halt_req(halt_req),
        .i_step_req(step_req), .i_step_num(step_num), .i_bp_en(bp_en), .i_bp_addr(bp_addr),
        .i_pc(pc), .i_insn_vld(insn_vld), .o_core_en(core_en), .o_halted(halted),
        .o_halt_cause(cause), .o_retired(retired), .o_step_left(step_left)
    );

    typedef struct packed {
        logic        en;
        logic        halted;
        logic [2:0]  cause;
        logic [31:0] ret;
        logic [15:0] left;
    } exp_t;

    exp_t q[$];
    int passed = 0, total = 0, en_cnt = 0, c0;
    // Model: mode 0 halted, 1 running, 2 stepping.
    int          m_mode;
    logic [2:0]  m_cause;
    logic [31:0] m_ret, m_pc, pc_mask;
    logic [15:0] m_left;
    logic        m_skip;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void model_reset();
        m_mode = 0; m_cause = 3'd0; m_ret = 32'd0; m_left = 16'd0; m_skip = 1'b1; m_pc = 32'd0;
    endfunction

    task automatic cyc(input logic run, input logic halt, input logic step,
                       input logic [15:0] num, input logic vld);
        logic hit, en;
        @(negedge clk);
        run_req = run; halt_req = halt; step_req = step; step_num = num; insn_vld = vld; pc = m_pc;
        #1;
        hit = bp_en && (m_pc == bp_addr) && !m_skip;
        en  = (m_mode != 0) && vld && !hit;
        q.push_back('{en, (m_mode == 0), m_cause, m_ret, m_left});
        if (m_mode == 0) begin
            if (step) begin m_mode = 2; m_left = (num == 16'd0) ? 16'd1 : num; end
            else if (run) m_mode = 1;
            if (step || run) begin m_skip = 1'b1; m_cause = 3'd0; end
        end else if (halt) begin
            m_mode = 0; m_cause = 3'd1;
        end else if (!vld) begin
            m_mode = 0; m_cause = 3'd4;
        end else if (hit) begin
            m_mode = 0; m_cause = 3'd3;
        end else if (m_mode == 2) begin
            m_left = m_left - 16'd1;
            if (m_left == 16'd0) begin m_mode = 0; m_cause = 3'd2; end
        end
        if (en) begin m_ret = m_ret + 32'd1; m_skip = 1'b0; m_pc = (m_pc + 32'd4) & pc_mask; end
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
        #1;
        check("rst_core_en", 32'(core_en), 32'd0);
        check("rst_halted", 32'(halted), 32'd1);
        check("rst_cause", 32'(cause), 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_step_left", 32'(step_left), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    always @(negedge clk) begin
        #2;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("sb_core_en", 32'(core_en), 32'(e.en));
            check("sb_halted", 32'(halted), 32'(e.halted));
            check("sb_cause", 32'(cause), 32'(e.cause));
            check("sb_retired", retired, e.ret);
            check("sb_step_left", 32'(step_left), 32'(e.left));
            if (core_en) en_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0; step_num = 16'd0;
        bp_en = 1'b0; bp_addr = 32'd0; insn_vld = 1'b1; pc = 32'd0; pc_mask = 32'hFFFF_FFFF;
        model_reset();
        do_reset();
        repeat (2) idle();
        // Step of three instructions.
        c0 = en_cnt;
        cyc(1'b0, 1'b0, 1'b1, 16'd3, 1'b1);
        repeat (5) idle();
        check("step3_en_cycles", 32'(en_cnt - c0), 32'd3);
        check("step3_retired", retired, 32'd3);
        check("step3_cause", 32'(cause), 32'd2);
        check("step3_left", 32'(step_left), 32'd0);
        check("step3_halted", 32'(halted), 32'd1);
        // Step count 0 behaves as 1.
        c0 = en_cnt;
        cyc(1'b0, 1'b0, 1'b1, 16'd0, 1'b1);
        repeat (4) idle();
        check("step0_en_cycles", 32'(en_cnt - c0), 32'd1);
        check("step0_cause", 32'(cause), 32'd2);
        check("step0_retired", retired, 32'd4);
        // Breakpoint at 0x10, then resume past it.
        do_reset();
        bp_en = 1'b1; bp_addr = 32'h10;
        cyc(1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
        repeat (8) idle();
        check("bp_cause", 32'(cause), 32'd3);
        check("bp_retired", retired, 32'd4);
        check("bp_halted", 32'(halted), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
        repeat (3) idle();
        cyc(1'b0, 1'b1, 1'b0, 16'd0, 1'b1);
        idle();
        check("bp_resume_retired", retired, 32'd8);
        check("bp_resume_cause", 32'(cause), 32'd1);
        bp_en = 1'b0;
        // Invalid instruction while running.
        cyc(1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
        repeat (2) idle();
        cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        idle();
        check("ill_cause", 32'(cause), 32'd4);
        check("ill_retired", retired, 32'd10);
        // Halt and step together while running: halt wins, step ignored.
        cyc(1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
        idle();
        cyc(1'b0, 1'b1, 1'b1, 16'd7, 1'b1);
        repeat (2) idle();
        check("hs_cause", 32'(cause), 32'd1);
        check("hs_halted", 32'(halted), 32'd1);
        check("hs_left", 32'(step_left), 32'd0);
        check("hs_retired", retired, 32'd12);
        // Randomized traffic over a small PC loop so breakpoints recur.
        pc_mask = 32'h3C;
        m_pc = m_pc & pc_mask;
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                bp_en = 1'($urandom_range(0, 1));
                bp_addr = 32'($urandom_range(0, 15)) << 2;
            end
            cyc($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 11) == 0,
                16'($urandom_range(0, 5)), $urandom_range(0, 15) != 0);
        end
        // Retired counter wrap.
        bp_en = 1'b0;
        pc_mask = 32'hFFFF_FFFF;
        cyc(1'b0, 1'b1, 1'b0, 16'd0, 1'b1);
        idle();
        #2;
        force dut.retired = 32'hFFFF_FFFF;
        #1;
        release dut.retired;
        m_ret = 32'hFFFF_FFFF;
        check("wrap_preload", retired, 32'hFFFF_FFFF);
        cyc(1'b0, 1'b0, 1'b1, 16'd1, 1'b1);
        repeat (2) idle();
        check("wrap_retired", retired, 32'd0);
        check("wrap_cause", 32'(cause), 32'd2);
        // Asynchronous reset in the middle of a step.
        cyc(1'b0, 1'b0, 1'b1, 16'd10, 1'b1);
        repeat (3) idle();
        check("midstep_active", 32'(core_en), 32'd1);
        do_reset();
        repeat (2) idle();
        check("post_reset_halted", 32'(halted), 32'd1);
        #5;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
